// File: rtl/mult_pkg.sv
// Shared helpers for the pipelined multiplier wrappers: sizing functions and the
// two's-complement correction applied to an unsigned WIDTH x WIDTH product.
package mult_pkg;

    // Widest operand the correction function can serve.
    localparam int unsigned MaxWidth = 64;

    function automatic int unsigned occ_width(input int unsigned stages);
        return $clog2(stages + 2);
    endfunction

    function automatic int unsigned prod_width(input int unsigned width);
        return 2 * width;
    endfunction

    // Result is exact modulo 2^(2*width); callers keep the low 2*width bits.
    function automatic logic [2*MaxWidth-1:0] signed_fix(
        input logic [2*MaxWidth-1:0] pu,
        input logic [MaxWidth-1:0]   a,
        input logic [MaxWidth-1:0]   b,
        input int unsigned           width,
        input logic                  is_signed
    );
        logic [2*MaxWidth-1:0]       r;
        logic [$clog2(MaxWidth)-1:0] msb;
        r   = pu;
        msb = $clog2(MaxWidth)'(width - 1);
        if (is_signed) begin
            if (a[msb]) r = r - ({{MaxWidth{1'b0}}, b} << width);
            if (b[msb]) r = r - ({{MaxWidth{1'b0}}, a} << width);
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_core.sv
// Combinational unsigned WIDTH x WIDTH multiplier.
module mult_core #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product
);

    assign product = (2*WIDTH)'(multiplicand) * (2*WIDTH)'(multiplier);

endmodule

// File: rtl/mult_pipe_wrapper.sv
// Valid/ready pipeline around mult_core: an operand stage S0 followed by PIPE_STAGES
// product stages, each with its own valid bit so bubbles collapse under backpressure.
module mult_pipe_wrapper
    import mult_pkg::*;
#(
    parameter int unsigned  WIDTH       = 16,
    parameter int unsigned  PIPE_STAGES = 1,
    localparam int unsigned PW          = prod_width(WIDTH),
    localparam int unsigned OW          = occ_width(PIPE_STAGES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    product,
    output logic [OW-1:0]    occupancy
);

    logic [WIDTH-1:0]   a_q, b_q;
    logic               sgn_q;
    logic               v0_q;
    logic               v_q    [1:PIPE_STAGES];
    logic [PW-1:0]      prod_q [1:PIPE_STAGES];
    logic [PIPE_STAGES:0] vld;
    logic [PIPE_STAGES:0] en;
    logic [PW-1:0]      pu;
    logic [PW-1:0]      prod_fix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
            v0_q  <= 1'b0;
        end else if (en[0]) begin
            a_q   <= multiplicand;
            b_q   <= multiplier;
            sgn_q <= is_signed;
            v0_q  <= in_valid;
        end
    end

    mult_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .multiplicand (a_q),
        .multiplier   (b_q),
        .product      (pu)
    );

    assign prod_fix = PW'(signed_fix((2*MaxWidth)'(pu), MaxWidth'(a_q), MaxWidth'(b_q),
                                     WIDTH, sgn_q));

    always_comb begin
        vld[0] = v0_q;
        for (int i = 1; i <= int'(PIPE_STAGES); i++) vld[i] = v_q[i];
    end

    // A stage may load if it is empty or the stage after it is moving.
    always_comb begin
        en = '0;
        en[PIPE_STAGES] = !vld[PIPE_STAGES] || out_ready;
        for (int i = int'(PIPE_STAGES) - 1; i >= 0; i--) en[i] = !vld[i] || en[i+1];
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i <= int'(PIPE_STAGES); i++) occupancy = occupancy + OW'(vld[i]);
    end

    for (genvar gi = 1; gi <= PIPE_STAGES; gi++) begin : g_stage
        logic [PW-1:0] prod_d;
        logic          v_d;

        if (gi == 1) begin : g_first
            assign prod_d = prod_fix;
            assign v_d    = v0_q;
        end else begin : g_next
            assign prod_d = prod_q[gi-1];
            assign v_d    = v_q[gi-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prod_q[gi] <= '0;
                v_q[gi]    <= 1'b0;
            end else if (en[gi]) begin
                prod_q[gi] <= prod_d;
                v_q[gi]    <= v_d;
            end
        end
    end

    assign in_ready  = en[0];
    assign out_valid = v_q[PIPE_STAGES];
    assign product   = prod_q[PIPE_STAGES];

endmodule

// File: doc/mult_pipe_wrapper.md
# mult_pipe_wrapper

Parametrised, flow-controlled pipeline wrapper around the combinational multiplier core. Operands and mode are captured on a valid/ready handshake and carried through a configurable number of product register stages. Each stage holds its own valid bit, so bubbles collapse and backpressure stalls only the stages that are full. It sits between a streaming producer and consumer and lets multiplier PPA runs be characterised at several widths and pipeline depths with both signed and unsigned operation.

## Interface

Parameters:
- WIDTH, 16, operand width in bits (≥2).
- PIPE_STAGES, 1, number of product register stages after the operand stage (1..4).

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  wrapper can accept this cycle.
- multiplicand  in  WIDTH  operand A.
- multiplier  in  WIDTH  operand B.
- is_signed  in  1  1 = two's-complement A×B, 0 = unsigned; travels with the operands.
- out_valid  out  1  product beat present.
- out_ready  in  1  consumer accepts this cycle.
- product  out  2*WIDTH  result, exact in the chosen mode.
- occupancy  out  $clog2(PIPE_STAGES+2)  number of valid stages (S0..SN).

## Operation

- Stages: S0 holds the operand and mode registers. S1..SN (N = PIPE_STAGES) hold the product registers. Each stage has a valid bit v_i.
- Per-stage enables: en_N = !v_N || out_ready; en_i = !v_i || en_(i+1) for i < N.
- in_ready = en_0.
- Load rules:
  - S0 loads when en_0; v_0 <= in_valid.
  - S1 loads the core result and v_0 when en_1.
  - S(i+1) loads from Si when en_(i+1).
- Core: unsigned WIDTH×WIDTH multiply of the S0 operands.
- Signed correction, applied combinationally before S1: P = Pu − (A[W−1] ? B<<W : 0) − (B[W−1] ? A<<W : 0), taken modulo 2^(2W) and gated by the S0 is_signed bit.
- A stage whose enable is low holds its data and valid bit unchanged.
- product and out_valid come directly from SN. There is no combinational path from in_* to out_*.
- occupancy = popcount(v_0..v_N), registered-derived and combinational from the valid bits.
- Boundary conditions:
  - Full pipe with out_ready low: in_ready = 0 and no data changes.
  - Full pipe with out_ready high: the pipe accepts and retires in the same cycle, at throughput 1/cycle.
  - in_valid high while in_ready low: the beat is not taken, and the producer must hold it.
  - Back-to-back mode changes: each beat uses its own captured is_signed.
  - Reset mid-flight: all in-flight beats are discarded and nothing is emitted after reset.

## Timing

- Reset (asynchronous assert, synchronous deassert at the system level): all v_i = 0, all data registers = 0, product = 0, out_valid = 0, occupancy = 0. in_ready = 1 from the first cycle after reset.
- Latency: a beat accepted at edge t is presented on product/out_valid after edge t+N. With N=1 the result is visible 2 cycles after the input cycle.
- Throughput: 1 beat/cycle when out_ready is held high.
- Stall: dropping out_ready does not drop in_ready until all N+1 stages are valid.
- in_ready depends combinationally on out_ready through a ripple chain of depth N+1.

## Structure

- Shared package mult_pkg holds:
  - the function that computes the occupancy width;
  - the localparam PW = 2*WIDTH helper;
  - the signed-correction function, so that other multiplier wrappers reuse it.
- One sub-module is natural: the combinational multiplier core, instantiated unchanged as mult_core with ports multiplicand, multiplier, product.
- The stage registers are a generate loop over 1..PIPE_STAGES in the top module.

## Test plan

- Reset then single beat (WIDTH=16, N=1): A=0xFFFF, B=0xFFFF, is_signed=0 -> product 0xFFFE0001, out_valid high after 2 edges for exactly one cycle with out_ready=1.
- Signed beat: A=0xFFFF (−1), B=0x0003, is_signed=1 -> product 0xFFFFFFFD; the same operands with is_signed=0 -> 0x0002FFFD.
- Streaming (N=3): 100 random beats with in_valid and out_ready held at 1 -> in_ready stays 1, one result per cycle, in order, latency 4 edges, all matching the reference model.
- Backpressure: fill the pipe with out_ready=0 -> in_ready falls after N+1 accepted beats and occupancy = N+1. Then toggle out_ready 1/0 -> no loss, no duplication, order preserved.
- Bubble collapse: one beat, two idle cycles, one beat, with out_ready=0 -> both beats are held in adjacent tail stages and occupancy = 2. Raising out_ready drains them on consecutive cycles.
- Reset mid-flight: assert rst_n=0 with 3 beats in flight -> out_valid=0, product=0, occupancy=0 immediately. After release, nothing is emitted until a new beat is accepted.
